// File: rtl/serial_adder_if.sv
// Purpose: operand/result bundle for the bit-serial adder (request side and result side).
// Latency: none; the bundle only groups wires.
// Backpressure: the master must wait for busy=0 before a new start is taken.
//
// Ports / signals:
//   start      master->slave  request, honoured only while the adder is idle
//   a, b, cin  master->slave  operands, captured on the accept edge
//   busy       slave->master  request in progress (RUN and DONE)
//   done       slave->master  one-cycle pulse, sum/cout just updated
//   sum, cout  slave->master  registered result, held until the next completion
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder.sv
// Purpose: bit-serial adder, {cout,sum} = a + b + cin, one bit pair per cycle, LSB first.
// Latency: accept at edge T, result and done at edge T+WIDTH, idle again after T+WIDTH+1.
// Backpressure: start is ignored while busy; no queueing, the requester must retry.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any operation in flight
//   bus    serial_adder_if slave modport (start/a/b/cin in, busy/done/sum/cout out)
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             load;
   logic             last;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             done_q;

   // one full-add bit built from two cascaded half-add stages
   logic s1;
   logic c1;
   logic s;
   logic c2;
   logic carry_nxt;

   always_comb begin
      s1        = a_sh[0] ^ b_sh[0];
      c1        = a_sh[0] & b_sh[0];
      s         = s1 ^ carry;
      c2        = s1 & carry;
      carry_nxt = c1 | c2;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and control decode
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt == LAST_BIT) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // datapath: operand shifters, carry flop, sum shifter, bit counter, result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         s_sh   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         // done is high only for the cycle spent in DONE
         done_q <= last;
         if (load) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            s_sh  <= '0;
            cnt   <= '0;
         end else if (state_q == RUN) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            carry <= carry_nxt;
            // sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
            s_sh  <= {s, s_sh[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
            if (last) begin
               sum_q  <= {s, s_sh[WIDTH-1:1]};
               cout_q <= carry_nxt;
            end
         end
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Purpose: directed bench for serial_adder (WIDTH=8) with a result scoreboard.
// Latency: checks done at accept+8 edges and the busy window around it.
// Backpressure: drives start during busy and confirms it is dropped.
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;

   logic [WIDTH:0] exp_q[$];
   logic [WIDTH:0] mon_exp;
   logic [WIDTH:0] last_res;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result", 64'({bus.cout, bus.sum}), 64'(mon_exp));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // one request, then follow it to completion checking busy, held result and latency
   task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
      logic [WIDTH:0] e;
      int c;
      e = {1'b0, xa} + {1'b0, xb} + {{WIDTH{1'b0}}, xc};
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = xa; bus.b = xb; bus.cin = xc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      // operands are free to change after the accept edge
      bus.start = 1'b0;
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      bus.cin   = 1'($urandom);
      @(negedge clk);
      c = 1;
      while (!bus.done && c <= 40) begin
         check("run_busy_held", 64'({bus.busy, bus.cout, bus.sum}), 64'({1'b1, last_res}));
         @(posedge clk);
         @(negedge clk);
         c++;
      end
      check("latency", 64'(c - 1), 64'(WIDTH));
      check("done_busy", 64'(bus.busy), 64'd1);
      last_res = e;
      @(negedge clk);
      check("after_done", 64'({bus.busy, bus.done, bus.cout, bus.sum}), 64'({2'b00, e}));
   endtask

   initial begin
      int d0;
      int c;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      last_res  = '0;

      repeat (3) @(posedge clk);
      #2;
      check("in_reset", 64'({bus.busy, bus.done, bus.cout, bus.sum}), 64'd0);
      rst_n = 1'b1;

      // idle with start low
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle", 64'({bus.busy, bus.done, bus.cout, bus.sum}), 64'd0);
      end

      run_op(8'h12, 8'h34, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'h5A, 8'hA5, 1'b1);
      run_op(8'h80, 8'h7F, 1'b0);

      // start asserted while busy is dropped
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
      exp_q.push_back(9'h002);
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("ignored_done_count", 64'(done_cnt - d0), 64'd1);
      check("ignored_result", 64'({bus.busy, bus.cout, bus.sum}), 64'h002);
      last_res = 9'h002;

      // asynchronous reset mid-operation
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", 64'({bus.busy, bus.done, bus.cout, bus.sum}), 64'd0);
      d0 = done_cnt;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
      check("idle_after_reset", 64'({bus.busy, bus.done, bus.cout, bus.sum}), 64'd0);
      last_res = '0;

      run_op(8'h03, 8'h04, 1'b0);

      // start held high: one operation every WIDTH+2 cycles
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
      d0 = done_cnt;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(9'h030);
      end
      for (int k = 0; k < 3; k++) begin
         c = 0;
         do begin
            @(posedge clk);
            @(negedge clk);
            c++;
         end while (!bus.done && c < 40);
         // the first count includes the accept edge itself
         check("held_start_gap", 64'(c), (k == 0) ? 64'(WIDTH + 1) : 64'(WIDTH + 2));
      end
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("held_start_done_count", 64'(done_cnt - d0), 64'd3);
      check("held_start_idle", 64'({bus.busy, bus.done, bus.cout, bus.sum}), 64'h030);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
